// File: rtl/reg_bridge_pkg.sv
// Shared types and default latencies for the Avalon-MM to register-decoder bridge.
package reg_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_STB  = 3'd1,
    WR_HOLD = 3'd2,
    RD_STB  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } bridge_state_t;

  localparam int DEF_RD_LAT = 5;
  localparam int DEF_WR_LAT = 4;

  // Counter preload: a latency of N is covered by counting N-1 down to 0.
  function automatic logic [3:0] lat_preload(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/avmm_reg_bridge.sv
// Avalon-MM slave to decoder strobe bus, one transaction in flight; ack after Read/WriteLatency+2 cycles,
// waitrequest held high until then. REG_BRIDGE_POSTED_WR_EN: writes are acked at accept and finish in the background.
module avmm_reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int AddrWidth    = 16,
  parameter int BusWidth     = 32,
  parameter int ReadLatency  = DEF_RD_LAT,
  parameter int WriteLatency = DEF_WR_LAT
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic                 avs_chipselect,
  input  logic [AddrWidth-3:0] avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [BusWidth-1:0]  avs_writedata,
  output logic [BusWidth-1:0]  avs_readdata,
  output logic                 avs_waitrequest,
  output logic                 chip_sel,
  output logic                 read_reg,
  output logic                 write_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_to_cpu
);

`ifdef REG_BRIDGE_POSTED_WR_EN
  localparam bit PostedWr = 1'b1;
`else
  localparam bit PostedWr = 1'b0;
`endif

  bridge_state_t        state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-3:0] addr_q, addr_d;
  logic [BusWidth-1:0]  wdata_q, wdata_d;
  logic [BusWidth-1:0]  rdata_q, rdata_d;
  logic                 chip_sel_q, chip_sel_d;
  logic                 posted_q, posted_d;
  logic                 waitreq;
  logic                 accept;

  assign accept = avs_chipselect & (avs_read | avs_write);

  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      chip_sel_q <= 1'b0;
      posted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      chip_sel_q <= chip_sel_d;
      posted_q   <= posted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    chip_sel_d = chip_sel_q;
    posted_d   = posted_q;
    waitreq    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = avs_address;
          wdata_d    = avs_writedata;
          chip_sel_d = 1'b1;
          // A simultaneous read is dropped: write has priority.
          if (avs_write) begin
            state_d  = WR_STB;
            posted_d = PostedWr;
            waitreq  = ~PostedWr | reset_in;
          end else begin
            state_d = RD_STB;
          end
        end
      end
      WR_STB: begin
        cnt_d   = lat_preload(WriteLatency);
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_STB: begin
        cnt_d   = lat_preload(ReadLatency);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = busdata_to_cpu;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // A posted write was already acknowledged at accept time.
        waitreq    = posted_q;
        chip_sel_d = 1'b0;
        posted_d   = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = waitreq;
  assign chip_sel        = chip_sel_q;
  assign read_reg        = (state_q == RD_STB);
  assign write_reg       = (state_q == WR_STB);
  assign busaddress      = addr_q;
  assign busdata_in      = wdata_q;

endmodule
